mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller in front of a word-wide DataMem.
// Aligned words go straight through; byte/half stores take a two-cycle read-modify-write.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] dm_rdata,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        stall,
    output logic        misaligned
);

    localparam int unsigned WORD_WIDTH = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [WORD_WIDTH-1:0]   r_addr;
    logic [WORD_WIDTH-1:0]   r_merged;
    logic [WORD_WIDTH-1:0]   r_rdata;
    logic                    r_rdata_valid;
    logic                    r_misaligned;

    logic                    w_is_byte;
    logic                    w_is_half;
    logic                    w_is_word;
    logic                    w_misal;
    logic [WORD_WIDTH-1:0]   w_aligned;
    logic [WORD_WIDTH-1:0]   w_merged;
    logic [WORD_WIDTH-1:0]   w_load_ext;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic                    w_dm_we;
    logic                    w_stall;
    logic [WORD_WIDTH-1:0]   w_dm_addr;
    logic [WORD_WIDTH-1:0]   w_dm_wdata;
    logic                    w_load_fire;
    logic                    w_rmw_start;
    logic                    w_misal_fire;

    // Size decode; size 11 behaves as a word access
    assign w_is_byte = (req_size == 2'b00);
    assign w_is_half = (req_size == 2'b01);
    assign w_is_word = req_size[1];
    assign w_misal   = (w_is_half && req_addr[0]) || (w_is_word && (req_addr[1:0] != 2'b00));
    assign w_aligned = {req_addr[31:2], 2'b00};

    // Little-endian lane extraction and extension for loads
    assign w_byte = dm_rdata[{req_addr[1:0], 3'b000} +: 8];
    assign w_half = dm_rdata[{req_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_ext = dm_rdata;
        if (w_is_byte) begin
            w_load_ext = {{24{~req_unsigned & w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            w_load_ext = {{16{~req_unsigned & w_half[15]}}, w_half};
        end
    end

    // Current memory word with the target lane replaced by the store data
    always_comb begin
        w_merged = dm_rdata;
        if (w_is_byte) begin
            w_merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        end else if (w_is_half) begin
            w_merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_dm_we      = 1'b0;
        w_stall      = 1'b0;
        w_dm_addr    = w_aligned;
        w_dm_wdata   = req_wdata;
        w_load_fire  = 1'b0;
        w_rmw_start  = 1'b0;
        w_misal_fire = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_misal) begin
                        w_misal_fire = 1'b1;
                    end else if (!req_we) begin
                        w_load_fire = 1'b1;
                    end else if (w_is_word) begin
                        w_dm_we = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_rmw_start = 1'b1;
                        w_next      = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                w_dm_we    = 1'b1;
                w_dm_addr  = r_addr;
                w_dm_wdata = r_merged;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Reset kills any write or stall in the same cycle, including a pending RMW
        if (rst) begin
            w_dm_we      = 1'b0;
            w_stall      = 1'b0;
            w_load_fire  = 1'b0;
            w_rmw_start  = 1'b0;
            w_misal_fire = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr        <= '0;
            r_merged      <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_rdata_valid <= w_load_fire;
            r_misaligned  <= w_misal_fire;
            if (w_load_fire) begin
                r_rdata <= w_load_ext;
            end
            if (w_rmw_start) begin
                r_addr   <= w_aligned;
                r_merged <= w_merged;
            end
        end
    end

    assign dm_we       = w_dm_we;
    assign dm_addr     = w_dm_addr;
    assign dm_wdata    = w_dm_wdata;
    assign stall       = w_stall;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases plus random traffic against a byte-lane memory model.
module tb_mem_access_ctrl;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] dm_rdata;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        stall;
    logic        misaligned;

    logic [31:0] env_mem [0:15];
    logic [31:0] ref_mem [0:15];
    logic [31:0] ref_rdata;
    logic        poke;
    logic [3:0]  poke_idx;
    logic [31:0] poke_data;
    int          checks;
    int          errors;

    mem_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .dm_rdata     (dm_rdata),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .stall        (stall),
        .misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMem stand-in: combinational read, write on clock edge
    assign dm_rdata = env_mem[dm_addr[5:2]];
    always @(posedge clk) begin
        if (poke) env_mem[poke_idx] <= poke_data;
        else if (dm_we) env_mem[dm_addr[5:2]] <= dm_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = v;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    task automatic poke_word(input int idx, input logic [31:0] data);
        set_req(1'b0, 1'b0, 2'b00, 1'b0, BASE, 32'h0);
        poke      = 1'b1;
        poke_idx  = 4'(idx);
        poke_data = data;
        @(posedge clk);
        #1;
        poke = 1'b0;
        ref_mem[idx] = data;
    endtask

    // One request evaluated against byte-lane rules, then its full occupancy
    task automatic do_req(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input string tag);
        int          nb;
        int          lane;
        int          idx;
        logic        mis;
        logic        ld;
        logic        st_word;
        logic        st_sub;
        logic [31:0] exp_word;
        logic [31:0] val;
        logic [31:0] mask;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lane = int'(addr[1:0]);
        idx  = int'(addr[5:2]);
        mis     = v && ((lane % nb) != 0);
        ld      = v && !mis && !we;
        st_word = v && !mis && we && (nb == 4);
        st_sub  = v && !mis && we && (nb < 4);

        exp_word = ref_mem[idx];
        for (int i = 0; i < nb; i++) exp_word[8*(lane+i) +: 8] = wd[8*i +: 8];
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nb)) - 32'h1);
        val  = (ref_mem[idx] >> (8*lane)) & mask;
        if (!uns && nb < 4 && val[8*nb-1]) val = val | ~mask;

        set_req(v, we, sz, uns, addr, wd);
        #1;
        check({tag, "_stall"}, 32'(stall), 32'(st_sub));
        check({tag, "_dm_we"}, 32'(dm_we), 32'(st_word));
        check({tag, "_dm_addr"}, dm_addr, {addr[31:2], 2'b00});
        if (st_word) check({tag, "_dm_wdata"}, dm_wdata, wd);
        @(posedge clk);
        #1;
        if (ld) ref_rdata = val;
        check({tag, "_rvalid"}, 32'(rdata_valid), 32'(ld));
        check({tag, "_misal"}, 32'(misaligned), 32'(mis));
        check({tag, "_rdata"}, rdata, ref_rdata);
        if (st_sub) begin
            set_req(1'b1, 1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                    BASE | 32'($urandom % 64), $urandom);
            #1;
            check({tag, "_rmw_we"}, 32'(dm_we), 32'd1);
            check({tag, "_rmw_stall"}, 32'(stall), 32'd0);
            check({tag, "_rmw_addr"}, dm_addr, {addr[31:2], 2'b00});
            check({tag, "_rmw_wdata"}, dm_wdata, exp_word);
            @(posedge clk);
            #1;
            check({tag, "_rmw_rvalid"}, 32'(rdata_valid), 32'd0);
            check({tag, "_rmw_misal"}, 32'(misaligned), 32'd0);
        end
        if (st_word || st_sub) ref_mem[idx] = exp_word;
        check({tag, "_mem"}, env_mem[idx], ref_mem[idx]);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        poke      = 1'b0;
        poke_idx  = 4'd0;
        poke_data = 32'h0;
        ref_rdata = 32'h0;
        rst       = 1'b1;
        set_req(1'b1, 1'b1, 2'b10, 1'b0, BASE, 32'hDEAD_BEEF);
        #1;
        check("rst_dm_we", 32'(dm_we), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 16; i++) poke_word(i, (i == 0) ? 32'h8899_AABB : $urandom);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rvalid", 32'(rdata_valid), 32'd0);
        check("rst_misal", 32'(misaligned), 32'd0);
        rst = 1'b0;

        do_req(1'b1, 1'b0, 2'b00, 1'b0, BASE + 32'd2, 32'h0, "lb");
        check("lb_value", rdata, 32'hFFFF_FF99);
        do_req(1'b1, 1'b0, 2'b00, 1'b1, BASE + 32'd2, 32'h0, "lbu");
        check("lbu_value", rdata, 32'h0000_0099);
        do_req(1'b1, 1'b1, 2'b00, 1'b0, BASE + 32'd1, 32'h12, "sb");
        check("sb_word", env_mem[0], 32'h8899_12BB);
        poke_word(0, 32'h8899_AABB);
        do_req(1'b1, 1'b1, 2'b01, 1'b0, BASE + 32'd2, 32'hCAFE, "sh");
        check("sh_word", env_mem[0], 32'hCAFE_AABB);
        do_req(1'b1, 1'b0, 2'b01, 1'b1, BASE + 32'd2, 32'h0, "lhu");
        check("lhu_value", rdata, 32'h0000_CAFE);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'd6, 32'h0, "lw_misal");
        do_req(1'b1, 1'b1, 2'b10, 1'b0, BASE + 32'd4, 32'h0123_4567, "sw");
        do_req(1'b1, 1'b0, 2'b01, 1'b0, BASE + 32'd6, 32'h0, "lh");
        check("lh_value", rdata, 32'h0000_0123);

        // Reset during the write half of a byte store drops that write
        set_req(1'b1, 1'b1, 2'b00, 1'b0, BASE + 32'd9, 32'h5A);
        #1;
        check("abort_c0_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_dm_we", 32'(dm_we), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_rdata = 32'h0;
        check("abort_rdata", rdata, 32'h0);
        check("abort_rvalid", 32'(rdata_valid), 32'd0);
        check("abort_mem", env_mem[2], ref_mem[2]);
        do_req(1'b1, 1'b1, 2'b00, 1'b0, BASE + 32'd9, 32'h5A, "sb_after_rst");

        for (int n = 0; n < 300; n++) begin
            do_req(($urandom % 5) != 0, 1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                   BASE | 32'($urandom % 64), $urandom, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
